vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Generates the VGA raster position and sync timing that drives the pixel colour application logic. It produces the horizontal/vertical pixel coordinates consumed by zone selection, plus hsync, vsync and blanking for the DAC/connector. A clock-enable divider derives the pixel rate from the system clock. Each axis runs a phase state machine (ACTIVE, FRONT, SYNC, BACK).

Parameters:
- CLK_DIV, 2, system clocks per pixel; 2 gives 25 MHz from 50 MHz. Legal values are 1 or more.
- H_ACTIVE, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BACK, 33, vertical back porch in lines.

Ports:
- clk_in  input  1  system clock.
- reset_in  input  1  synchronous reset, active-high.
- pixel_tick  output  1  pixel-rate enable, high for one clk_in cycle every CLK_DIV cycles.
- horizontal  output  10  current pixel column; counts 0 to H_TOTAL-1.
- vertical  output  10  current line; counts 0 to V_TOTAL-1.
- hsync_n  output  1  horizontal sync, active-low.
- vsync_n  output  1  vertical sync, active-low.
- video_on  output  1  high when both axes are in ACTIVE.
- frame_start  output  1  one-cycle pulse when the raster wraps to (0,0).

Behaviour:
- Derived totals: H_TOTAL = sum of H_* = 800; V_TOTAL = sum of V_* = 525. Both must fit in 10 bits.
- Reset is synchronous: on any clk_in edge with reset_in=1, all state is cleared.
- Reset values: divider count=0, pixel_tick=0, horizontal=0, vertical=0, both FSMs in ACTIVE, hsync_n=1, vsync_n=1, video_on=1, frame_start=0.
- Reset mid-frame discards the position immediately. The first tick after release advances horizontal from 0 to 1.
- Divider:
  - Counts 0..CLK_DIV-1; pixel_tick=1 in the cycle the count equals CLK_DIV-1.
  - With CLK_DIV=1, pixel_tick is constantly 1 after reset.
  - The first pixel_tick occurs CLK_DIV cycles after reset is released.
- Horizontal counter:
  - Advances only on a clk_in edge where pixel_tick=1.
  - At H_TOTAL-1 it wraps to 0 and asserts an internal line_end.
- Vertical counter:
  - Advances only on an edge where pixel_tick=1 and line_end=1.
  - At V_TOTAL-1 it wraps to 0.
- Horizontal FSM transitions (state is evaluated on the value the counter takes on that edge):
  - ACTIVE to FRONT when h becomes H_ACTIVE.
  - FRONT to SYNC when h becomes H_ACTIVE+H_FRONT.
  - SYNC to BACK when h becomes H_ACTIVE+H_FRONT+H_SYNC.
  - BACK to ACTIVE when h wraps to 0.
- Vertical FSM has identical transitions using the V_* parameters, stepped only on line_end.
- Output registration:
  - All outputs are registered and mutually consistent within a cycle: hsync_n, vsync_n and video_on always correspond to the horizontal/vertical value shown in the same cycle.
  - hsync_n=0 exactly for h=656..751; vsync_n=0 exactly for v=490..491.
  - video_on=1 exactly for h<640 and v<480.
- frame_start is high for one clk_in cycle, coincident with the edge that moves (799,524) to (0,0). It is not asserted by reset.
- horizontal and vertical keep counting through blanking; consumers must gate colour with video_on.
- Counters hold their value between ticks.

Optional Feature:
VGA_FRAME_COUNT_EN
- Defined:
  - Adds output frame_count [7:0], reset 0.
  - Increments on the same edge frame_start asserts and wraps 255 to 0.
  - Used for on-screen animation and blink effects.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package vga_pkg holds:
  - typedef enum logic [1:0] vga_phase_t {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK}.
  - Default 640x480@60 timing constants.
  - localparam COORD_W=10.
- Sub-module vga_axis_counter:
  - Parameterized by ACTIVE/FRONT/SYNC/BACK.
  - Inputs: clk_in, reset_in, step.
  - Outputs: count, phase, wrap, sync_n, active.
  - Instantiated twice: horizontal uses step=pixel_tick; vertical uses step=pixel_tick & h_wrap.
- The top level contains the divider, the frame_start register and the optional frame counter.

Test Plan:
- Reset release, CLK_DIV=2: pixel_tick first high on cycle 2, then every 2 cycles; horizontal=1 after the first tick; hsync_n=vsync_n=1 and video_on=1 throughout.
- Run one line: hsync_n falls on the tick where h becomes 656 and rises where h becomes 752; video_on falls where h becomes 640; wrap at 799 to 0 increments vertical by 1.
- Run a full frame: vsync_n low for lines 490-491 only; frame_start pulses exactly once, at (0,0) after 800*525*2 = 840000 cycles; no pulse at reset.
- Assert reset_in for one cycle at (400,300): next cycle shows horizontal=0, vertical=0, hsync_n=1, vsync_n=1, video_on=1; the next tick gives h=1.
- CLK_DIV=1 with small timing (H 4/1/1/1, V 3/1/1/1): pixel_tick constantly 1; full 7x6 sequence checked cycle by cycle against a reference model.
- VGA_FRAME_COUNT_EN defined: frame_count reads 0, 1, 2 after successive frames and wraps 255 to 0 after 256 frames.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing constants for the VGA raster generator.
package vga_pkg;

   localparam int COORD_W = 10;

   localparam int DEF_CLK_DIV  = 2;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FRONT  = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BACK   = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FRONT  = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BACK   = 33;

   typedef enum logic [1:0] {
      PH_ACTIVE,
      PH_FRONT,
      PH_SYNC,
      PH_BACK
   } vga_phase_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase machine.
// Phase, sync and active are all decided from the count being loaded, so they line up with it.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int ACTIVE = 640,
   parameter int FRONT  = 16,
   parameter int SYNC   = 96,
   parameter int BACK   = 48
) (
   input  logic               clk_in,
   input  logic               reset_in,
   input  logic               step,
   output logic [COORD_W-1:0] count,
   output vga_phase_t         phase,
   output logic               wrap,
   output logic               sync_n,
   output logic               active
);

   localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;
   localparam logic [COORD_W-1:0] LAST        = COORD_W'(TOTAL - 1);
   localparam logic [COORD_W-1:0] FRONT_START = COORD_W'(ACTIVE);
   localparam logic [COORD_W-1:0] SYNC_START  = COORD_W'(ACTIVE + FRONT);
   localparam logic [COORD_W-1:0] BACK_START  = COORD_W'(ACTIVE + FRONT + SYNC);
   localparam logic [COORD_W-1:0] ONE         = COORD_W'(1);

   logic [COORD_W-1:0] count_q, count_d;
   vga_phase_t         phase_q, phase_d;
   logic               sync_n_q, sync_n_d;
   logic               active_q, active_d;
   logic               wrap_c;

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         count_q  <= '0;
         phase_q  <= PH_ACTIVE;
         sync_n_q <= 1'b1;
         active_q <= 1'b1;
      end else begin
         count_q  <= count_d;
         phase_q  <= phase_d;
         sync_n_q <= sync_n_d;
         active_q <= active_d;
      end
   end

   always_comb begin
      count_d = count_q;
      phase_d = phase_q;
      wrap_c  = step && (count_q == LAST);
      if (step) begin
         count_d = wrap_c ? '0 : count_q + ONE;
      end
      case (phase_q)
         PH_ACTIVE: if (step && count_d == FRONT_START) phase_d = PH_FRONT;
         PH_FRONT:  if (step && count_d == SYNC_START)  phase_d = PH_SYNC;
         PH_SYNC:   if (step && count_d == BACK_START)  phase_d = PH_BACK;
         PH_BACK:   if (wrap_c)                         phase_d = PH_ACTIVE;
         default:   phase_d = PH_ACTIVE;
      endcase
      sync_n_d = (phase_d != PH_SYNC);
      active_d = (phase_d == PH_ACTIVE);
   end

   assign count  = count_q;
   assign phase  = phase_q;
   assign wrap   = wrap_c;
   assign sync_n = sync_n_q;
   assign active = active_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster/sync generator: pixel-rate divider, two axis counters, frame_start pulse.
// Define VGA_FRAME_COUNT_EN to add the 8-bit frame_count output.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FRONT  = DEF_H_FRONT,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BACK   = DEF_H_BACK,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FRONT  = DEF_V_FRONT,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BACK   = DEF_V_BACK
) (
   input  logic               clk_in,
   input  logic               reset_in,
   output logic               pixel_tick,
   output logic [COORD_W-1:0] horizontal,
   output logic [COORD_W-1:0] vertical,
   output logic               hsync_n,
   output logic               vsync_n,
   output logic               video_on,
`ifdef VGA_FRAME_COUNT_EN
   output logic [7:0]         frame_count,
`endif
   output logic               frame_start
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             tick_q, tick_d;
   logic             frame_start_q, frame_start_d;

   logic       h_wrap, v_wrap, h_sync_n, v_sync_n, h_active, v_active;
   vga_phase_t h_phase, v_phase;

   // Tick is registered from the old count, so it first rises CLK_DIV cycles after reset.
   always_comb begin
      div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;
      tick_d = (div_q == DIV_LAST);
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         div_q         <= '0;
         tick_q        <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         div_q         <= div_d;
         tick_q        <= tick_d;
         frame_start_q <= frame_start_d;
      end
   end

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FRONT  (H_FRONT),
      .SYNC   (H_SYNC),
      .BACK   (H_BACK)
   ) u_h_axis (
      .clk_in   (clk_in),
      .reset_in (reset_in),
      .step     (tick_q),
      .count    (horizontal),
      .phase    (h_phase),
      .wrap     (h_wrap),
      .sync_n   (h_sync_n),
      .active   (h_active)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FRONT  (V_FRONT),
      .SYNC   (V_SYNC),
      .BACK   (V_BACK)
   ) u_v_axis (
      .clk_in   (clk_in),
      .reset_in (reset_in),
      .step     (tick_q & h_wrap),
      .count    (vertical),
      .phase    (v_phase),
      .wrap     (v_wrap),
      .sync_n   (v_sync_n),
      .active   (v_active)
   );

   // A vertical wrap only happens on the last pixel of the last line, both axes in BACK.
   assign frame_start_d = v_wrap && (h_phase == PH_BACK) && (v_phase == PH_BACK);

`ifdef VGA_FRAME_COUNT_EN
   logic [7:0] frame_count_q;

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         frame_count_q <= '0;
      end else if (frame_start_d) begin
         frame_count_q <= frame_count_q + 8'd1;
      end
   end

   assign frame_count = frame_count_q;
`endif

   assign pixel_tick  = tick_q;
   assign hsync_n     = h_sync_n;
   assign vsync_n     = v_sync_n;
   assign video_on    = h_active & v_active;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: DUT A uses CLK_DIV=2 with full-width lines and a short 12-line frame,
// DUT B uses CLK_DIV=1 with a tiny 7x6 raster for cycle-exact and frame-count checks.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, rst_b;
   logic       a_tick, a_hs, a_vs, a_von, a_fs;
   logic [9:0] a_h, a_v;
   logic       b_tick, b_hs, b_vs, b_von, b_fs;
   logic [9:0] b_h, b_v;
`ifdef VGA_FRAME_COUNT_EN
   logic [7:0] a_fc, b_fc;
`endif

   int checks = 0;
   int fails  = 0;

   vga_timing_gen #(
      .CLK_DIV (2),
      .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
   ) dut_a (
      .clk_in      (clk),
      .reset_in    (rst_a),
      .pixel_tick  (a_tick),
      .horizontal  (a_h),
      .vertical    (a_v),
      .hsync_n     (a_hs),
      .vsync_n     (a_vs),
      .video_on    (a_von),
`ifdef VGA_FRAME_COUNT_EN
      .frame_count (a_fc),
`endif
      .frame_start (a_fs)
   );

   vga_timing_gen #(
      .CLK_DIV (1),
      .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
      .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
   ) dut_b (
      .clk_in      (clk),
      .reset_in    (rst_b),
      .pixel_tick  (b_tick),
      .horizontal  (b_h),
      .vertical    (b_v),
      .hsync_n     (b_hs),
      .vsync_n     (b_vs),
      .video_on    (b_von),
`ifdef VGA_FRAME_COUNT_EN
      .frame_count (b_fc),
`endif
      .frame_start (b_fs)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (3) cyc();
      checks++;
      if ({a_tick, a_h, a_v, a_hs, a_vs, a_von, a_fs} !== {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL reset_state got tick=%0d h=%0d v=%0d hs=%0d vs=%0d von=%0d fs=%0d exp 0 0 0 1 1 1 0",
                  a_tick, a_h, a_v, a_hs, a_vs, a_von, a_fs);
      end
      rst_a = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         cyc();
         checks++;
         if ({a_tick, a_h, a_hs, a_vs, a_von} !== {(k % 2 == 0), 10'((k - 1) / 2), 1'b1, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL release_cycle%0d got tick=%0d h=%0d hs=%0d vs=%0d von=%0d exp tick=%0d h=%0d 1 1 1",
                     k, a_tick, a_h, a_hs, a_vs, a_von, (k % 2 == 0), (k - 1) / 2);
         end
      end
      $display("test_reset: done, checks=%0d fails=%0d", checks, fails);
   endtask

   task automatic test_line();
      int  fall_h = -1, rise_h = -1, von_h = -1;
      bit  done = 0;
      logic       p_tick, p_hs, p_von;
      logic [9:0] p_h, p_v, e_h, e_v;
      for (int n = 0; n < 2000 && !done; n++) begin
         p_tick = a_tick; p_h = a_h; p_v = a_v; p_hs = a_hs; p_von = a_von;
         cyc();
         e_h = p_tick ? ((p_h == 10'd799) ? 10'd0 : p_h + 10'd1) : p_h;
         e_v = (p_tick && p_h == 10'd799) ? p_v + 10'd1 : p_v;
         checks++;
         if ({a_h, a_v, a_hs, a_von} !== {e_h, e_v, !(e_h >= 656 && e_h <= 751), (e_h < 640 && e_v < 6)}) begin
            fails++;
            $display("FAIL line_step got h=%0d v=%0d hs=%0d von=%0d exp h=%0d v=%0d", a_h, a_v, a_hs, a_von, e_h, e_v);
         end
         if (p_hs && !a_hs) fall_h = a_h;
         if (!p_hs && a_hs) rise_h = a_h;
         if (p_von && !a_von) von_h = a_h;
         if (a_v == 10'd1) done = 1;
      end
      checks++;
      if (!done || a_h !== 10'd0) begin
         fails++;
         $display("FAIL line_wrap got h=%0d v=%0d exp h=0 v=1", a_h, a_v);
      end
      checks++;
      if (fall_h != 656 || rise_h != 752 || von_h != 640) begin
         fails++;
         $display("FAIL line_edges got hs_fall=%0d hs_rise=%0d von_fall=%0d exp 656 752 640", fall_h, rise_h, von_h);
      end
      $display("test_line: done, checks=%0d fails=%0d", checks, fails);
   endtask

   task automatic test_frame();
      int  vs_low = 0, pulses = 0;
      bit  done = 0;
      logic       p_tick, e_fs;
      logic [9:0] p_h, p_v;
      for (int n = 0; n < 25000 && !done; n++) begin
         p_tick = a_tick; p_h = a_h; p_v = a_v;
         cyc();
         e_fs = p_tick && p_h == 10'd799 && p_v == 10'd11;
         checks++;
         if ({a_vs, a_von, a_fs} !== {!(a_v == 10'd8 || a_v == 10'd9), (a_h < 640 && a_v < 6), e_fs}) begin
            fails++;
            $display("FAIL frame_flags at h=%0d v=%0d got vs=%0d von=%0d fs=%0d exp fs=%0d", a_h, a_v, a_vs, a_von, a_fs, e_fs);
         end
         if (!a_vs) vs_low++;
         if (a_fs) begin
            pulses++;
            done = 1;
         end
      end
      checks++;
      if (!done || a_h !== 10'd0 || a_v !== 10'd0) begin
         fails++;
         $display("FAIL frame_start_pos got done=%0d h=%0d v=%0d exp 1 0 0", done, a_h, a_v);
      end
      repeat (20) begin
         cyc();
         if (a_fs) pulses++;
      end
      checks++;
      if (pulses != 1 || vs_low != 3200) begin
         fails++;
         $display("FAIL frame_counts got pulses=%0d vsync_low_cycles=%0d exp 1 3200", pulses, vs_low);
      end
      $display("test_frame: done, checks=%0d fails=%0d", checks, fails);
   endtask

   task automatic test_reset_mid();
      bit found = 0;
      for (int n = 0; n < 30000 && !found; n++) begin
         cyc();
         if (a_h == 10'd400 && a_v == 10'd3) found = 1;
      end
      checks++;
      if (!found) begin
         fails++;
         $display("FAIL mid_reach got h=%0d v=%0d exp 400 3", a_h, a_v);
      end
      rst_a = 1'b1;
      cyc();
      rst_a = 1'b0;
      checks++;
      if ({a_tick, a_h, a_v, a_hs, a_vs, a_von, a_fs} !== {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL mid_reset got tick=%0d h=%0d v=%0d hs=%0d vs=%0d von=%0d fs=%0d exp 0 0 0 1 1 1 0",
                  a_tick, a_h, a_v, a_hs, a_vs, a_von, a_fs);
      end
      for (int k = 1; k <= 3; k++) begin
         cyc();
         checks++;
         if ({a_tick, a_h} !== {(k == 2), 10'((k == 3) ? 1 : 0)}) begin
            fails++;
            $display("FAIL mid_release%0d got tick=%0d h=%0d exp tick=%0d h=%0d", k, a_tick, a_h, (k == 2), (k == 3) ? 1 : 0);
         end
      end
      $display("test_reset_mid: done, checks=%0d fails=%0d", checks, fails);
   endtask

   task automatic test_clkdiv1();
      int         mh = 0, mv = 0, pulses = 0;
      logic       mt = 1'b0, e_fs;
      rst_b = 1'b1;
      repeat (2) cyc();
      checks++;
      if ({b_tick, b_h, b_v, b_hs, b_vs, b_von, b_fs} !== {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL div1_reset got tick=%0d h=%0d v=%0d exp 0 0 0", b_tick, b_h, b_v);
      end
      rst_b = 1'b0;
      for (int n = 0; n < 91; n++) begin
         e_fs = mt && mh == 6 && mv == 5;
         if (mt) begin
            if (mh == 6) begin
               mh = 0;
               mv = (mv == 5) ? 0 : mv + 1;
            end else begin
               mh = mh + 1;
            end
         end
         mt = 1'b1;
         cyc();
         if (b_fs) pulses++;
         checks++;
         if ({b_tick, b_h, b_v} !== {mt, 10'(mh), 10'(mv)}) begin
            fails++;
            $display("FAIL div1_pos cycle %0d got tick=%0d h=%0d v=%0d exp tick=%0d h=%0d v=%0d", n, b_tick, b_h, b_v, mt, mh, mv);
         end
         checks++;
         if ({b_hs, b_vs, b_von, b_fs} !== {(mh != 5), (mv != 4), (mh < 4 && mv < 3), e_fs}) begin
            fails++;
            $display("FAIL div1_flags cycle %0d got hs=%0d vs=%0d von=%0d fs=%0d exp hs=%0d vs=%0d von=%0d fs=%0d",
                     n, b_hs, b_vs, b_von, b_fs, (mh != 5), (mv != 4), (mh < 4 && mv < 3), e_fs);
         end
      end
      checks++;
      if (pulses != 2) begin
         fails++;
         $display("FAIL div1_pulses got %0d exp 2", pulses);
      end
      $display("test_clkdiv1: done, checks=%0d fails=%0d", checks, fails);
   endtask

`ifdef VGA_FRAME_COUNT_EN
   task automatic test_frame_count();
      int pulses = 0;
      rst_b = 1'b1;
      cyc();
      checks++;
      if (b_fc !== 8'd0) begin
         fails++;
         $display("FAIL fc_reset got %0d exp 0", b_fc);
      end
      rst_b = 1'b0;
      for (int n = 0; n < 12000 && pulses < 256; n++) begin
         cyc();
         if (b_fs) begin
            pulses++;
            if (pulses == 1 || pulses == 2 || pulses == 255 || pulses == 256) begin
               checks++;
               if (b_fc !== 8'(pulses)) begin
                  fails++;
                  $display("FAIL fc_frame%0d got %0d exp %0d", pulses, b_fc, pulses % 256);
               end
            end
         end
      end
      checks++;
      if (pulses != 256) begin
         fails++;
         $display("FAIL fc_timeout got %0d frames exp 256", pulses);
      end
      $display("test_frame_count: done, checks=%0d fails=%0d", checks, fails);
   endtask
`endif

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      test_reset();
      test_line();
      test_frame();
      test_reset_mid();
      test_clkdiv1();
`ifdef VGA_FRAME_COUNT_EN
      test_frame_count();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
